decoder_scan: RTL and testbench

Parametrised, registered binary-to-one-hot decoder: IN_W-bit code in, 2**IN_W-bit one-hot word out. Two modes. Direct mode decodes codes accepted over a valid/ready handshake. Scan mode steps autonomously through every code with a programmable dwell, and is used for decoder sweeps and output-line bring-up. It replaces the fixed 4-to-16 combinational decoder wherever a registered, handshaked or self-sequencing decode is needed.

---
 rtl/decoder_pkg.sv | 28 ++
 rtl/decoder_dwell_cnt.sv | 49 ++++
 rtl/decoder_scan.sv | 190 +++++++++++++++++++
 tb/tb_decoder_scan.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared types and helpers for the decoder_scan block.
//   state_e          : top-level FSM state encoding
//   onehot()         : code -> one-hot vector, MaxOutW wide; callers keep the low OUT_W bits
//   DefaultInW       : default code width
//   DefaultStepCycles: default scan dwell per code, in clock cycles
package decoder_pkg;

  localparam int unsigned DefaultInW        = 4;
  localparam int unsigned DefaultStepCycles = 5;

  // Widest code the helper supports; decoder_scan needs IN_W < MaxInW.
  localparam int unsigned MaxInW  = 12;
  localparam int unsigned MaxOutW = 1 << MaxInW;

  typedef enum logic [1:0] {
    StIdle,
    StDirect,
    StScan
  } state_e;

  function automatic logic [MaxOutW-1:0] onehot(input logic [MaxInW-1:0] code);
    logic [MaxOutW-1:0] oh;
    oh       = '0;
    oh[code] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/decoder_dwell_cnt.sv
// Dwell down-counter for scan mode.
// Counts STEP_CYCLES-1 down to 0 and reloads itself, so tc_o fires once every
// STEP_CYCLES enabled cycles.
//   clk_i, rst_ni : clock, async active-low reset
//   clr_i         : force the count to 0 (highest priority)
//   load_i        : load STEP_CYCLES-1
//   en_i          : count enable
//   tc_o          : terminal count, high on an enabled cycle with count == 0
module decoder_dwell_cnt
  import decoder_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = DefaultStepCycles
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic load_i,
  input  logic en_i,
  output logic tc_o
);

  // A single-cycle dwell still needs a 1-bit register.
  localparam int unsigned CntW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CntW-1:0] LoadVal = CntW'(STEP_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tc_o = en_i & (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i || tc_o) begin
      cnt_d = LoadVal;
    end else if (en_i) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/decoder_scan.sv
// Registered binary-to-one-hot decoder with direct (valid/ready) and scan modes.
// Build option: define DECODER_SCAN_AUTO_EN to compile in scan mode and the dwell
// counter. Without it, mode_i is ignored, the block always runs IDLE -> DIRECT and
// scan_done_o is tied low.
//   clk_i, rst_ni : clock, async active-low reset
//   mode_i        : 0 = direct, 1 = scan
//   en_i          : output enable, gates x_o only (combinational)
//   in_valid_i    : code valid (direct mode)
//   in_ready_o    : block can accept a code
//   in_i          : code to decode
//   x_o           : registered one-hot output, x_o[k] = 1 for code k
//   code_o        : registered copy of the code currently decoded
//   x_valid_o     : one-cycle pulse when x/code take a new value
//   scan_done_o   : one-cycle pulse when a full sweep wraps back to code 0
module decoder_scan
  import decoder_pkg::*;
#(
  parameter int unsigned IN_W        = DefaultInW,
  parameter int unsigned STEP_CYCLES = DefaultStepCycles,
  localparam int unsigned OUT_W      = 1 << IN_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             mode_i,
  input  logic             en_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [IN_W-1:0]  in_i,
  output logic [OUT_W-1:0] x_o,
  output logic [IN_W-1:0]  code_o,
  output logic             x_valid_o,
  output logic             scan_done_o
);

  state_e state_q, state_d;

  // Set on the first edge after reset release; holds the FSM off until then so
  // the first transition lands one edge later.
  logic run_q;

  logic [IN_W-1:0]    code_q, code_d;
  logic [OUT_W-1:0]   x_q, x_d;
  logic               x_valid_q, x_valid_d;
  logic               scan_done_q, scan_done_d;
  logic               in_ready_q, in_ready_d;
  logic               x_load;
  logic [MaxOutW-1:0] oh_full;
  logic               accept;
  logic               scan_mode;
  logic               dwell_tc;
  logic               dwell_clr;
  logic               dwell_load;

  assign accept = in_valid_i & in_ready_q;

`ifdef DECODER_SCAN_AUTO_EN
  logic dwell_en;

  assign scan_mode = mode_i;
  assign dwell_en  = run_q & (state_q == StScan) & mode_i;

  decoder_dwell_cnt #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_dwell_cnt (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .clr_i (dwell_clr),
    .load_i(dwell_load),
    .en_i  (dwell_en),
    .tc_o  (dwell_tc)
  );
`else
  logic        unused_mode;
  logic        unused_dwell;
  logic [31:0] unused_step;

  assign scan_mode    = 1'b0;
  assign dwell_tc     = 1'b0;
  assign unused_mode  = mode_i;
  assign unused_dwell = dwell_clr ^ dwell_load;
  assign unused_step  = STEP_CYCLES;
`endif

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    x_d         = x_q;
    x_valid_d   = 1'b0;
    scan_done_d = 1'b0;
    in_ready_d  = in_ready_q;
    x_load      = 1'b0;
    dwell_clr   = 1'b0;
    dwell_load  = 1'b0;

    if (run_q) begin
      unique case (state_q)
        StIdle: begin
          code_d     = '0;
          x_d        = '0;
          in_ready_d = 1'b0;
          dwell_clr  = 1'b1;
          if (scan_mode) begin
            state_d    = StScan;
            x_load     = 1'b1;
            x_valid_d  = 1'b1;
            dwell_clr  = 1'b0;
            dwell_load = 1'b1;
          end else begin
            state_d    = StDirect;
            in_ready_d = 1'b1;
          end
        end

        StDirect: begin
          if (accept) begin
            code_d    = in_i;
            x_load    = 1'b1;
            x_valid_d = 1'b1;
          end
          if (scan_mode) begin
            // An accept in the same cycle as a mode change still completes; ready
            // drops so the following edge can leave without losing a code.
            in_ready_d = 1'b0;
            if (!accept) begin
              state_d = StIdle;
              code_d  = '0;
              x_d     = '0;
            end
          end else begin
            in_ready_d = 1'b1;
          end
        end

        StScan: begin
          if (!scan_mode) begin
            // Abort: clear everything, no sweep-done pulse.
            state_d   = StIdle;
            code_d    = '0;
            x_d       = '0;
            dwell_clr = 1'b1;
          end else if (dwell_tc) begin
            code_d      = code_q + IN_W'(1);
            x_load      = 1'b1;
            x_valid_d   = 1'b1;
            scan_done_d = (code_q == '1);
          end
        end

        default: begin
          state_d = StIdle;
        end
      endcase
    end

    oh_full = onehot(MaxInW'(code_d));
    if (x_load) begin
      x_d = oh_full[OUT_W-1:0];
    end
  end

  logic unused_oh;
  assign unused_oh = ^oh_full[MaxOutW-1:OUT_W];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      run_q       <= 1'b0;
      code_q      <= '0;
      x_q         <= '0;
      x_valid_q   <= 1'b0;
      scan_done_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= 1'b1;
      code_q      <= code_d;
      x_q         <= x_d;
      x_valid_q   <= x_valid_d;
      scan_done_q <= scan_done_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign x_o         = en_i ? x_q : '0;
  assign code_o      = code_q;
  assign x_valid_o   = x_valid_q;
  assign scan_done_o = scan_done_q;
  assign in_ready_o  = in_ready_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Directed bench for decoder_scan: a 4-bit direct-mode instance driven from a vector
// table, plus a 2-bit / 3-cycle-dwell instance for scan, abort and mode-ignore cases.
module tb_decoder_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;

  logic        m4, e4, v4, r4, xv4, sd4;
  logic [3:0]  i4, c4;
  logic [15:0] x4;

  logic        m2, e2, v2, r2, xv2, sd2;
  logic [1:0]  i2, c2;
  logic [3:0]  x2;

  decoder_scan #(
    .IN_W(4)
  ) u_dut4 (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .mode_i     (m4),
    .en_i       (e4),
    .in_valid_i (v4),
    .in_ready_o (r4),
    .in_i       (i4),
    .x_o        (x4),
    .code_o     (c4),
    .x_valid_o  (xv4),
    .scan_done_o(sd4)
  );

  decoder_scan #(
    .IN_W       (2),
    .STEP_CYCLES(3)
  ) u_dut2 (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .mode_i     (m2),
    .en_i       (e2),
    .in_valid_i (v2),
    .in_ready_o (r2),
    .in_i       (i2),
    .x_o        (x2),
    .code_o     (c2),
    .x_valid_o  (xv2),
    .scan_done_o(sd2)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  code;
    logic        en;
    logic [15:0] exp_x;
  } vec_t;

  vec_t vecs[17];

  initial begin
    vecs[0]  = '{4'd1,  1'b1, 16'h0002};
    vecs[1]  = '{4'd2,  1'b1, 16'h0004};
    vecs[2]  = '{4'd3,  1'b1, 16'h0008};
    vecs[3]  = '{4'd4,  1'b1, 16'h0010};
    vecs[4]  = '{4'd5,  1'b1, 16'h0020};
    vecs[5]  = '{4'd6,  1'b1, 16'h0040};
    vecs[6]  = '{4'd7,  1'b1, 16'h0080};
    vecs[7]  = '{4'd8,  1'b1, 16'h0100};
    vecs[8]  = '{4'd9,  1'b1, 16'h0200};
    vecs[9]  = '{4'd10, 1'b1, 16'h0400};
    vecs[10] = '{4'd11, 1'b1, 16'h0800};
    vecs[11] = '{4'd12, 1'b1, 16'h1000};
    vecs[12] = '{4'd13, 1'b1, 16'h2000};
    vecs[13] = '{4'd14, 1'b1, 16'h4000};
    vecs[14] = '{4'd15, 1'b1, 16'h8000};
    vecs[15] = '{4'd0,  1'b1, 16'h0001};
    vecs[16] = '{4'd7,  1'b0, 16'h0000};

    rst_n = 1'b0;
    m4 = 1'b0; e4 = 1'b1; v4 = 1'b0; i4 = '0;
    m2 = 1'b0; e2 = 1'b1; v2 = 1'b0; i2 = '0;

    repeat (3) step();
    check("rst_x", x4, 0);
    check("rst_code", c4, 0);
    check("rst_ready", r4, 0);
    check("rst_xvalid", xv4, 0);
    check("rst_done", sd4, 0);

    // Release: first edge only samples it, the second moves IDLE -> DIRECT.
    rst_n = 1'b1;
    step();
    check("ready_first_edge", r4, 0);
    step();
    check("ready_direct", r4, 1);
    check("ready_direct_b", r2, 1);

    // Back-to-back accepts from the table.
    for (int k = 0; k < 17; k++) begin
      i4 = vecs[k].code;
      e4 = vecs[k].en;
      v4 = 1'b1;
      step();
      check($sformatf("vec%0d_x", k), x4, vecs[k].exp_x);
      check($sformatf("vec%0d_code", k), c4, vecs[k].code);
      check($sformatf("vec%0d_xvalid", k), xv4, 1);
    end
    v4 = 1'b0;
    step();
    check("hold_xvalid", xv4, 0);
    check("hold_code", c4, 7);
    check("hold_x_en0", x4, 0);
    e4 = 1'b1;
    #1;
    check("en_rise_x", x4, 16'h0080);
    step();
    check("en_rise_xvalid", xv4, 0);
    check("en_rise_hold", x4, 16'h0080);

`ifdef DECODER_SCAN_AUTO_EN
    // Scan sweep on the 2-bit / 3-cycle instance.
    m2 = 1'b1;
    step();
    check("scan_exit_ready", r2, 0);
    check("scan_exit_x", x2, 0);
    step();
    check("scan_entry_xvalid", xv2, 1);
    check("scan_entry_code", c2, 0);
    check("scan_entry_x", x2, 4'b0001);
    for (int c = 1; c <= 19; c++) begin
      step();
      check($sformatf("scan%0d_code", c), c2, (c / 3) % 4);
      check($sformatf("scan%0d_x", c), x2, 1 << ((c / 3) % 4));
      check($sformatf("scan%0d_xvalid", c), xv2, (c % 3) == 0);
      check($sformatf("scan%0d_done", c), sd2, c == 12);
      check($sformatf("scan%0d_ready", c), r2, 0);
    end
    // Code is 2 and mid-dwell here; drop mode.
    m2 = 1'b0;
    step();
    check("abort_x", x2, 0);
    check("abort_code", c2, 0);
    check("abort_done", sd2, 0);
    check("abort_ready", r2, 0);
    check("abort_xvalid", xv2, 0);
    step();
    check("abort_redirect_ready", r2, 1);
    i2 = 2'd3;
    v2 = 1'b1;
    step();
    v2 = 1'b0;
    check("abort_accept_x", x2, 4'b1000);
    check("abort_accept_code", c2, 3);
`else
    // Mode is ignored: the block stays in direct mode.
    m2 = 1'b1;
    i2 = 2'd2;
    v2 = 1'b1;
    step();
    v2 = 1'b0;
    check("noscan_xvalid", xv2, 1);
    check("noscan_x", x2, 4'b0100);
    check("noscan_code", c2, 2);
    for (int c = 0; c < 6; c++) begin
      step();
      check($sformatf("noscan%0d_ready", c), r2, 1);
      check($sformatf("noscan%0d_done", c), sd2, 0);
      check($sformatf("noscan%0d_x", c), x2, 4'b0100);
    end
`endif

    // Asynchronous reset away from any clock edge.
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_x", x4, 0);
    check("arst_code", c4, 0);
    check("arst_ready", r4, 0);
    check("arst_xvalid", xv4, 0);
    check("arst_done", sd4, 0);
    check("arst_x2", x2, 0);
    check("arst_code2", c2, 0);
    check("arst_ready2", r2, 0);

    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
